adc_capture_ctrl: RTL and testbench

Parametrised capture controller between the SERDES/deserialiser outputs and the sample FIFO write port, in the adc_data_clk domain. Generalises the fixed 2-channel "write while trigger high" gating:
- N channels with per-channel enable masking.
- Armed single-shot counted capture or continuous capture.
- Sample decimation.
- Sticky overflow detection.
The FIFO itself, the clocking and host endpoints stay outside the block; control inputs arrive already synchronised to adc_data_clk.

---
 rtl/adc_capture_ctrl.sv | 176 +++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: gates deserialised samples into the FIFO write port.
// Supports channel masking, counted/continuous capture, decimation, overflow.
module adc_capture_ctrl #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int CNT_W    = 24,
    parameter int DECIM_W  = 8
) (
    input  logic                         adc_data_clk,
    input  logic                         reset,
    input  logic [NUM_CH*SAMPLE_W-1:0]   adc_data,
    input  logic                         adc_data_valid,
    input  logic                         front_end_ready,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         cont_mode,
    input  logic [CNT_W-1:0]             capture_len,
    input  logic [DECIM_W-1:0]           decim,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         fifo_prog_full,
    input  logic                         fifo_wr_rst_busy,
    output logic [NUM_CH*SAMPLE_W-1:0]   fifo_din,
    output logic                         fifo_wr_en,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [CNT_W-1:0]             sample_count
);

    localparam int DW = NUM_CH * SAMPLE_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                cont_q, cont_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [DECIM_W-1:0]  decim_q, decim_d;
    logic [NUM_CH-1:0]   chen_q, chen_d;
    logic [DECIM_W-1:0]  dec_q, dec_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                wr_q, wr_d;
    logic [DW-1:0]       din_q, din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DW-1:0]       masked;
    logic                wr_ok;
    logic [CNT_W-1:0]    cnt_inc;

    assign wr_ok   = !fifo_prog_full && !fifo_wr_rst_busy && front_end_ready;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Zero the lanes of disabled channels using the latched enable mask.
    always_comb begin
        masked = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (chen_q[k]) begin
                masked[k*SAMPLE_W +: SAMPLE_W] = adc_data[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Next-state logic for the capture FSM, decimation and write datapath.
    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        len_d   = len_q;
        decim_d = decim_q;
        chen_d  = chen_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        wr_d    = 1'b0;
        din_d   = din_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        cont_d  = cont_mode;
                        len_d   = capture_len;
                        decim_d = decim;
                        chen_d  = ch_enable;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        dec_d   = '0;
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (front_end_ready && !fifo_wr_rst_busy) begin
                        if (!cont_q && len_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CAP;
                        end
                    end
                end
                S_CAP: begin
                    if (adc_data_valid) begin
                        if (dec_q == '0) begin
                            dec_d = decim_q;
                            if (wr_ok) begin
                                wr_d  = 1'b1;
                                din_d = masked;
                                if (cont_q) begin
                                    if (cnt_q != '1) begin
                                        cnt_d = cnt_inc;
                                    end
                                end else begin
                                    cnt_d = cnt_inc;
                                    if (cnt_inc == len_q) begin
                                        state_d = S_DONE;
                                    end
                                end
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            dec_d = dec_q - DECIM_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_ARMED) || (state_d == S_CAP);
        done_d = (state_d == S_DONE);
    end

    // Register FSM state, shadow config, counters and all outputs.
    always_ff @(posedge adc_data_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cont_q  <= 1'b0;
            len_q   <= '0;
            decim_q <= '0;
            chen_q  <= '0;
            dec_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cont_q  <= cont_d;
            len_q   <= len_d;
            decim_q <= decim_d;
            chen_q  <= chen_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fifo_din     = din_q;
    assign fifo_wr_en   = wr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Testbench for adc_capture_ctrl: directed vectors, expected writes queued
// by stimulus and checked by an independent monitor on the falling edge.
module tb_adc_capture_ctrl;

    localparam int NUM_CH   = 2;
    localparam int SAMPLE_W = 16;
    localparam int CNT_W    = 24;
    localparam int DECIM_W  = 8;
    localparam int DW       = NUM_CH * SAMPLE_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [DW-1:0]       adc_data;
    logic                adc_data_valid;
    logic                front_end_ready;
    logic                arm;
    logic                abort;
    logic                cont_mode;
    logic [CNT_W-1:0]    capture_len;
    logic [DECIM_W-1:0]  decim;
    logic [NUM_CH-1:0]   ch_enable;
    logic                fifo_prog_full;
    logic                fifo_wr_rst_busy;
    logic [DW-1:0]       fifo_din;
    logic                fifo_wr_en;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [CNT_W-1:0]    sample_count;

    int total = 0;
    int bad   = 0;
    int wrs   = 0;
    logic [DW-1:0] expq[$];

    always #5 clk = ~clk;

    adc_capture_ctrl #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W),
        .CNT_W(CNT_W), .DECIM_W(DECIM_W)
    ) dut (
        .adc_data_clk(clk),
        .reset(reset),
        .adc_data(adc_data),
        .adc_data_valid(adc_data_valid),
        .front_end_ready(front_end_ready),
        .arm(arm),
        .abort(abort),
        .cont_mode(cont_mode),
        .capture_len(capture_len),
        .decim(decim),
        .ch_enable(ch_enable),
        .fifo_prog_full(fifo_prog_full),
        .fifo_wr_rst_busy(fifo_wr_rst_busy),
        .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .sample_count(sample_count)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            wrs++;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h expected none", fifo_din);
            end else begin
                chk("wr_data", 64'(fifo_din), 64'(expq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic cm, input int len,
                          input int dc, input logic [1:0] en);
        cont_mode   = cm;
        capture_len = CNT_W'(len);
        decim       = DECIM_W'(dc);
        ch_enable   = en;
        arm         = 1'b1;
        tick();
        arm         = 1'b0;
        cont_mode   = 1'b0;
        capture_len = '0;
        decim       = '0;
        ch_enable   = '0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pf);
        adc_data       = d;
        adc_data_valid = 1'b1;
        fifo_prog_full = pf;
        tick();
        adc_data_valid = 1'b0;
        fifo_prog_full = 1'b0;
    endtask

    function automatic logic [DW-1:0] mk(input int base, input int i);
        return {16'(base + 16'h0100 + i), 16'(base + i)};
    endfunction

    task automatic drain_check(input string name, input int w0, input int nexp);
        tick();
        tick();
        chk({name, "_writes"}, 64'(wrs - w0), 64'(nexp));
        chk({name, "_qempty"}, 64'(expq.size()), 64'd0);
    endtask

    initial begin
        int w0;
        reset = 1'b1;
        adc_data = '0;
        adc_data_valid = 1'b0;
        front_end_ready = 1'b1;
        arm = 1'b0;
        abort = 1'b0;
        cont_mode = 1'b0;
        capture_len = '0;
        decim = '0;
        ch_enable = '0;
        fifo_prog_full = 1'b0;
        fifo_wr_rst_busy = 1'b0;
        tick();
        tick();
        chk("rst_din", 64'(fifo_din), 64'd0);
        chk("rst_wr", 64'(fifo_wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_cnt", 64'(sample_count), 64'd0);
        reset = 1'b0;
        tick();

        // Counted 8, decim 0, ramp of 12 samples: first 8 written.
        w0 = wrs;
        do_arm(1'b0, 8, 0, 2'b11);
        chk("t1_busy_armed", 64'(busy), 64'd1);
        tick();
        for (int i = 0; i < 12; i++) begin
            if (i < 8) expq.push_back(mk(16'h1000, i));
            send(mk(16'h1000, i), 1'b0);
        end
        drain_check("t1", w0, 8);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_cnt", 64'(sample_count), 64'd8);
        chk("t1_ovf", 64'(overflow), 64'd0);

        // Decimate by 4, length 4: indices 0,4,8,12 kept.
        w0 = wrs;
        do_arm(1'b0, 4, 3, 2'b11);
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) expq.push_back(mk(16'h2000, i));
            send(mk(16'h2000, i), 1'b0);
        end
        drain_check("t2", w0, 4);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_cnt", 64'(sample_count), 64'd4);

        // Channel 1 masked off.
        w0 = wrs;
        do_arm(1'b0, 1, 0, 2'b01);
        tick();
        expq.push_back(32'h0000_5555);
        send({16'hAAAA, 16'h5555}, 1'b0);
        drain_check("t3", w0, 1);
        chk("t3_done", 64'(done), 64'd1);

        // prog_full on samples 3..5: overflow, still 10 writes.
        w0 = wrs;
        do_arm(1'b0, 10, 0, 2'b11);
        tick();
        for (int i = 0; i < 14; i++) begin
            logic pf;
            pf = (i >= 3 && i <= 5);
            if (!pf && i <= 12) expq.push_back(mk(16'h3000, i));
            send(mk(16'h3000, i), pf);
        end
        drain_check("t4", w0, 10);
        chk("t4_ovf", 64'(overflow), 64'd1);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_cnt", 64'(sample_count), 64'd10);

        // Continuous 20 samples then abort; then arm+abort together.
        w0 = wrs;
        do_arm(1'b1, 0, 0, 2'b11);
        chk("t5_ovf_clr", 64'(overflow), 64'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            expq.push_back(mk(16'h4000, i));
            send(mk(16'h4000, i), 1'b0);
        end
        chk("t5_busy_run", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_cnt", 64'(sample_count), 64'd20);
        abort = 1'b1;
        arm = 1'b1;
        cont_mode = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        cont_mode = 1'b0;
        tick();
        chk("t5_armabort_busy", 64'(busy), 64'd0);
        chk("t5_armabort_cnt", 64'(sample_count), 64'd20);
        drain_check("t5", w0, 20);

        // Front end not ready: no writes while armed.
        w0 = wrs;
        front_end_ready = 1'b0;
        do_arm(1'b0, 2, 0, 2'b11);
        for (int i = 0; i < 5; i++) send(mk(16'h5000, i), 1'b0);
        chk("t6_busy_wait", 64'(busy), 64'd1);
        chk("t6_nowr", 64'(wrs - w0), 64'd0);
        front_end_ready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            expq.push_back(mk(16'h5100, i));
            send(mk(16'h5100, i), 1'b0);
        end
        drain_check("t6", w0, 2);
        chk("t6_done", 64'(done), 64'd1);

        // Zero length: done once ready, no writes.
        w0 = wrs;
        front_end_ready = 1'b0;
        do_arm(1'b0, 0, 0, 2'b11);
        tick();
        chk("t7_busy", 64'(busy), 64'd1);
        front_end_ready = 1'b1;
        tick();
        tick();
        chk("t7_done", 64'(done), 64'd1);
        chk("t7_cnt", 64'(sample_count), 64'd0);
        drain_check("t7", w0, 0);

        // Reset mid-capture clears everything on the next edge.
        do_arm(1'b1, 0, 0, 2'b11);
        tick();
        for (int i = 0; i < 3; i++) begin
            expq.push_back(mk(16'h6000, i));
            send(mk(16'h6000, i), 1'b0);
        end
        reset = 1'b1;
        adc_data = mk(16'h6000, 3);
        adc_data_valid = 1'b1;
        tick();
        adc_data_valid = 1'b0;
        chk("t8_din", 64'(fifo_din), 64'd0);
        chk("t8_wr", 64'(fifo_wr_en), 64'd0);
        chk("t8_busy", 64'(busy), 64'd0);
        chk("t8_done", 64'(done), 64'd0);
        chk("t8_ovf", 64'(overflow), 64'd0);
        chk("t8_cnt", 64'(sample_count), 64'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("t8_qempty", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
